cache_plru_replace: RTL
=======================

Name: cache_plru_replace

Overview:
- Replacement stage directly downstream of the tag-compare/hit stage of the 8-way set-associative cache.
- Consumes the per-request set index, the hit flag, the hit way and the set's valid bits.
- Maintains a 7-bit tree pseudo-LRU state per set in internal storage.
- Returns the way to use: the hit way on a hit, or a victim way on a miss. Updates the PLRU state for accesses and invalidates.

Parameters:
- WAYS, 8, associativity. Fixed at 8; the tree encoding below depends on it.
- WAYS_REP, 3, width of a way number.
- INDEX, 14, set-index width. Number of sets = 2**INDEX. Benches override to 3.

Ports:
- clk  in  1  clock.
- rstb  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_index  in  INDEX  set index.
- req_hit  in  1  1 = upstream tag hit, 0 = miss.
- req_way  in  WAYS_REP  hit way. Used only when req_hit=1 or req_inv=1.
- req_inv  in  1  1 = invalidate of req_way; takes priority over req_hit.
- req_vbits  in  WAYS  valid bit of each line in the set.
- resp_valid  out  1  one-cycle response strobe.
- resp_way  out  WAYS_REP  way that was touched, allocated or invalidated.
- resp_fill_invalid  out  1  miss was filled into an invalid way, so no eviction is needed.
- init_done  out  1  PLRU storage cleared.

Behaviour:
- Request acceptance: a request is accepted on a rising clk edge when req_valid && req_ready. All req_* inputs are sampled on that edge.
- PLRU tree, bits b[6:0]:
  - b0 is the root; 0 = victim in ways 0-3, 1 = victim in ways 4-7.
  - b1 selects within ways 0-3 (0 = ways 0-1); b2 selects within ways 4-7 (0 = ways 4-5).
  - b3..b6 select within the pairs (0,1), (2,3), (4,5), (6,7); 0 = lower way.
- Touch(w): set the three path bits to point away from w.
- Demote(w): set the three path bits to point toward w.
- PLRU victim: walk the tree from b0 following the bits.
- States: INIT, IDLE, LOOKUP, COMMIT.
- Reset (rstb low, async):
  - state=INIT, init counter=0.
  - req_ready=0, resp_valid=0, resp_way=0, resp_fill_invalid=0, init_done=0.
  - Storage has no reset.
- INIT:
  - Writes 7'b0 to set[counter] once per cycle.
  - After writing set 2**INDEX-1, goes to IDLE and init_done=1, which holds until the next reset.
- IDLE: req_ready=1. An accepted request moves to LOOKUP.
- LOOKUP:
  - req_ready=0.
  - Reads the set's PLRU bits, or the bypass value (see same-index rule).
  - Computes the result way:
    - inv: result = req_way; new bits = Demote(req_way).
    - hit: result = req_way; new bits = Touch(req_way).
    - miss with any req_vbits bit 0: result = lowest-index invalid way; fill_invalid=1; new bits = Touch(result).
    - miss with all ways valid: result = PLRU victim; fill_invalid=0; new bits = Touch(result).
  - Registers the result and moves to COMMIT.
- COMMIT:
  - Writes the new bits to storage.
  - resp_valid=1 for exactly this cycle, with resp_way and resp_fill_invalid valid. For hit and inv, resp_fill_invalid=0.
  - req_ready=1. An accepted request goes directly to LOOKUP; otherwise the state returns to IDLE.
- Latency and throughput: resp_valid is asserted 2 cycles after acceptance. Maximum throughput is one request per 2 cycles.
- Same-index rule: if a request accepted in COMMIT has the same index as the committing request, its LOOKUP must use the bits just written, not stale storage.
- Reset mid-operation: any in-flight request is dropped. No resp_valid is issued, and the full INIT sweep restarts.
- Requests while in INIT are not accepted; req_valid is ignored.
- Outputs hold their last values in IDLE; only resp_valid deasserts.

Test Plan:
1. Reset with INDEX=3 -> init_done rises after exactly 8 cycles in INIT, and req_ready=0 throughout INIT.
2. Set 2, all vbits=1, miss -> resp_way=0, fill_invalid=0, bits=7'b0001011. A second miss on set 2 -> resp_way=4.
3. Set 5, vbits=8'b1111_0111, miss -> resp_way=3, fill_invalid=1. Repeat with vbits=8'hFF -> resp_way=4 (PLRU, way 3 was touched).
4. Set 1: hits on ways 0,4,2,6 -> then an all-valid miss returns way 1. inv way 5 -> the next all-valid miss returns way 5.
5. Back-to-back same index: a miss on set 3 (all valid), with a second request to set 3 accepted during COMMIT -> responses way 0 then way 4, resp_valid one cycle apart by 2.
6. rstb asserted during LOOKUP -> no resp_valid, INIT restarts, and set 2 afterwards returns victim way 0.

Source files
------------

// File: rtl/cache_plru_replace.sv
// Replacement stage for an 8-way set-associative cache: keeps a 7-bit tree
// pseudo-LRU state per set and returns the hit way or a victim way per request.
module cache_plru_replace #(
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3,
  parameter int INDEX    = 14
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INDEX-1:0]    req_index,
  input  logic                req_hit,
  input  logic [WAYS_REP-1:0] req_way,
  input  logic                req_inv,
  input  logic [WAYS-1:0]     req_vbits,
  output logic                resp_valid,
  output logic [WAYS_REP-1:0] resp_way,
  output logic                resp_fill_invalid,
  output logic                init_done,
  output logic [1:0]          dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is registered and only high in IDLE and COMMIT. resp_valid is a
  // one-cycle strobe with no back-pressure.

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_LOOKUP = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam int NSETS = 1 << INDEX;

  state_t              r_state;
  logic [INDEX-1:0]    r_cnt;
  logic [INDEX-1:0]    r_index;
  logic                r_hit;
  logic                r_inv;
  logic [WAYS_REP-1:0] r_way;
  logic [WAYS-1:0]     r_vbits;
  logic [6:0]          r_new_bits;
  logic                r_bypass;
  logic [6:0]          r_plru [0:NSETS-1];

  logic                w_accept;
  logic [6:0]          w_cur_bits;
  logic [WAYS_REP-1:0] w_res_way;
  logic                w_res_fill;
  logic [6:0]          w_res_bits;
  logic [WAYS_REP-1:0] w_low_inv;
  logic                w_any_inv;

  assign w_accept  = req_valid && req_ready;
  assign dbg_state = r_state;

  // Set the three path bits of way w: toward=1 points them at w, 0 away from w.
  function automatic logic [6:0] set_path(input logic [6:0] b,
                                          input logic [WAYS_REP-1:0] w,
                                          input logic toward);
    logic [6:0] n;
    n = b;
    n[0] = w[2] ^ ~toward;
    if (w[2]) n[2] = w[1] ^ ~toward;
    else      n[1] = w[1] ^ ~toward;
    n[3 + {1'b0, w[2:1]}] = w[0] ^ ~toward;
    return n;
  endfunction

  function automatic logic [WAYS_REP-1:0] plru_victim(input logic [6:0] b);
    logic l;
    logic m;
    l = b[0];
    m = l ? b[2] : b[1];
    return {l, m, b[3 + {1'b0, l, m}]};
  endfunction

  // The bypass covers a request accepted in COMMIT against the set being written.
  assign w_cur_bits = r_bypass ? r_new_bits : r_plru[r_index];

  always_comb begin
    w_low_inv = '0;
    w_any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_vbits[i]) begin
        w_low_inv = WAYS_REP'(i);
        w_any_inv = 1'b1;
      end
    end
  end

  always_comb begin
    w_res_way  = '0;
    w_res_fill = 1'b0;
    w_res_bits = w_cur_bits;
    if (r_inv) begin
      w_res_way  = r_way;
      w_res_bits = set_path(w_cur_bits, r_way, 1'b1);
    end else if (r_hit) begin
      w_res_way  = r_way;
      w_res_bits = set_path(w_cur_bits, r_way, 1'b0);
    end else if (w_any_inv) begin
      w_res_way  = w_low_inv;
      w_res_fill = 1'b1;
      w_res_bits = set_path(w_cur_bits, w_low_inv, 1'b0);
    end else begin
      w_res_way  = plru_victim(w_cur_bits);
      w_res_bits = set_path(w_cur_bits, plru_victim(w_cur_bits), 1'b0);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state           <= S_INIT;
      r_cnt             <= '0;
      r_index           <= '0;
      r_hit             <= 1'b0;
      r_inv             <= 1'b0;
      r_way             <= '0;
      r_vbits           <= '0;
      r_new_bits        <= '0;
      r_bypass          <= 1'b0;
      req_ready         <= 1'b0;
      resp_valid        <= 1'b0;
      resp_way          <= '0;
      resp_fill_invalid <= 1'b0;
      init_done         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {INDEX{1'b1}}) begin
            r_state   <= S_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_index   <= req_index;
            r_hit     <= req_hit;
            r_inv     <= req_inv;
            r_way     <= req_way;
            r_vbits   <= req_vbits;
            r_bypass  <= 1'b0;
            r_state   <= S_LOOKUP;
            req_ready <= 1'b0;
          end
        end
        S_LOOKUP: begin
          r_new_bits        <= w_res_bits;
          resp_way          <= w_res_way;
          resp_fill_invalid <= w_res_fill;
          resp_valid        <= 1'b1;
          req_ready         <= 1'b1;
          r_state           <= S_COMMIT;
        end
        S_COMMIT: begin
          if (w_accept) begin
            r_index   <= req_index;
            r_hit     <= req_hit;
            r_inv     <= req_inv;
            r_way     <= req_way;
            r_vbits   <= req_vbits;
            r_bypass  <= (req_index == r_index);
            r_state   <= S_LOOKUP;
            req_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_INIT)
      r_plru[r_cnt] <= '0;
    else if (r_state == S_COMMIT)
      r_plru[r_index] <= r_new_bits;
  end

endmodule
